// File: rtl/plus_int_ctrl_if.sv
// Bus between the Plus interrupt controller and the Gate-Array, CPU and DMA logic.
// The slave modport is the controller's view and the master modport is the driver's view.
interface plus_int_ctrl_if #(
    parameter int NUM_DMA = 3,
    parameter int LINE_W  = 8
);
    logic              hsync_i;
    logic              vsync_i;
    logic              pri_wr;
    logic [LINE_W-1:0] pri_line_i;
    logic              ivr_wr;
    logic [7:0]        ivr_i;
    logic [NUM_DMA-1:0] dma_irq;
    logic              int_enable;
    logic              cpu_ack;
    logic              int_n;
    logic [7:0]        vector;
    logic [NUM_DMA:0]  pending;

    modport master (
        output hsync_i, vsync_i, pri_wr, pri_line_i, ivr_wr, ivr_i,
               dma_irq, int_enable, cpu_ack,
        input  int_n, vector, pending
    );

    modport slave (
        input  hsync_i, vsync_i, pri_wr, pri_line_i, ivr_wr, ivr_i,
               dma_irq, int_enable, cpu_ack,
        output int_n, vector, pending
    );
endinterface

// File: rtl/plus_int_ctrl.sv
// Plus raster/frame and DMA interrupt controller with IM2 vector generation.
// pending[0] is raster/frame and pending[k] is DMA channel k-1. The frame timer is a down-counter.
module plus_int_ctrl #(
    parameter int CLK_FREQ_HZ    = 32_000_000,
    parameter int FRAME_DELAY_US = 52,
    parameter int NUM_DMA        = 3,
    parameter int LINE_W         = 8
) (
    input logic          clk,
    input logic          reset,
    plus_int_ctrl_if.slave bus
);
    localparam int FRAME_TICKS = CLK_FREQ_HZ / 1_000_000 * FRAME_DELAY_US;
    localparam int TMR_W       = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(FRAME_TICKS);
    localparam int PW          = NUM_DMA + 1;

    logic              hsync_s, hsync_p;
    logic              vsync_s, vsync_p;
    logic              ack_s, ack_p;
    logic [LINE_W-1:0] line_cnt;
    logic [LINE_W-1:0] pri_line;
    logic [7:0]        ivr;
    logic [TMR_W-1:0]  timer;
    logic              raster_hit;
    logic [PW-1:0]     pending;
    logic              int_n_q;
    logic [7:0]        vector_q;

    logic              hsync_fall, vsync_fall, ack_rise;
    logic              frame_mode, pri_cancel, frame_fire, raster_next;
    logic [PW-1:0]     win, set_v, clr_v, pending_nxt;
    logic [1:0]        ack_code;
    logic              found;
    logic [TMR_W-1:0]  timer_nxt;

    assign hsync_fall = hsync_p & ~hsync_s;
    assign vsync_fall = vsync_p & ~vsync_s;
    assign ack_rise   = ack_s & ~ack_p;

    assign frame_mode = (pri_line == '0);
    assign pri_cancel = bus.pri_wr & (bus.pri_line_i != '0);

    // A reload or a non-zero pri_line write in the final cycle aborts the count.
    assign frame_fire = frame_mode & ~pri_cancel & ~vsync_fall & (timer == TMR_W'(1));

    // Only the HSYNC edge that moves line_cnt onto pri_line hits, so a saturated counter cannot retrigger.
    assign raster_next = hsync_fall & ~vsync_fall & ~frame_mode &
                         (line_cnt != '1) & ((line_cnt + LINE_W'(1)) == pri_line);

    always_comb begin
        win      = '0;
        ack_code = 2'b00;
        found    = pending[0];
        if (pending[0]) begin
            win[0] = 1'b1;
        end
        // Highest DMA index wins. Channel k-1 uses code 3-(k-1).
        for (int k = NUM_DMA; k >= 1; k--) begin
            if (!found && pending[k]) begin
                found    = 1'b1;
                win[k]   = 1'b1;
                ack_code = 2'(4 - k);
            end
        end
    end

    always_comb begin
        set_v            = '0;
        set_v[0]         = frame_fire | raster_hit;
        set_v[PW-1:1]    = bus.dma_irq;
        clr_v            = ack_rise ? win : '0;
        pending_nxt      = (pending & ~clr_v) | set_v;
    end

    always_comb begin
        timer_nxt = timer;
        if (pri_cancel || !frame_mode) begin
            timer_nxt = '0;
        end else if (vsync_fall) begin
            timer_nxt = TMR_LOAD;
        end else if (timer != '0) begin
            timer_nxt = timer - TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_s    <= 1'b0;
            hsync_p    <= 1'b0;
            vsync_s    <= 1'b0;
            vsync_p    <= 1'b0;
            ack_s      <= 1'b0;
            ack_p      <= 1'b0;
            line_cnt   <= '0;
            pri_line   <= '0;
            ivr        <= 8'h00;
            timer      <= '0;
            raster_hit <= 1'b0;
            pending    <= '0;
            int_n_q    <= 1'b1;
            vector_q   <= 8'h00;
        end else begin
            hsync_s    <= bus.hsync_i;
            hsync_p    <= hsync_s;
            vsync_s    <= bus.vsync_i;
            vsync_p    <= vsync_s;
            ack_s      <= bus.cpu_ack;
            ack_p      <= ack_s;

            if (vsync_fall) begin
                line_cnt <= '0;
            end else if (hsync_fall && line_cnt != '1) begin
                line_cnt <= line_cnt + LINE_W'(1);
            end

            if (bus.pri_wr) begin
                pri_line <= bus.pri_line_i;
            end
            if (bus.ivr_wr) begin
                ivr <= bus.ivr_i;
            end

            timer      <= timer_nxt;
            raster_hit <= raster_next;
            pending    <= pending_nxt;
            int_n_q    <= ~((|pending) & bus.int_enable);

            if (ack_rise) begin
                vector_q <= {ivr[7:3], ack_code, 1'b0};
            end
        end
    end

    assign bus.int_n   = int_n_q;
    assign bus.vector  = vector_q;
    assign bus.pending = pending;
endmodule

// File: tb/tb_plus_int_ctrl.sv
// Directed bench for plus_int_ctrl: frame timer, raster compare, DMA priority, acknowledge and reset.
module tb_plus_int_ctrl;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    plus_int_ctrl_if #(.NUM_DMA(3), .LINE_W(8)) bus ();

    plus_int_ctrl #(
        .CLK_FREQ_HZ(32_000_000),
        .FRAME_DELAY_US(52),
        .NUM_DMA(3),
        .LINE_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic vsync_drop();
        bus.vsync_i = 1'b1;
        cyc(4);
        bus.vsync_i = 1'b0;
    endtask

    task automatic hsync_pulse();
        bus.hsync_i = 1'b1;
        cyc(3);
        bus.hsync_i = 1'b0;
        cyc(4);
    endtask

    task automatic ack_pulse();
        bus.cpu_ack = 1'b1;
        cyc(2);
        bus.cpu_ack = 1'b0;
        cyc(1);
    endtask

    task automatic pri_write(input logic [7:0] v);
        bus.pri_wr     = 1'b1;
        bus.pri_line_i = v;
        cyc(1);
        bus.pri_wr     = 1'b0;
    endtask

    task automatic dma_pulse(input logic [2:0] v);
        bus.dma_irq = v;
        cyc(1);
        bus.dma_irq = 3'b000;
    endtask

    initial begin
        n_chk          = 0;
        n_pass         = 0;
        reset          = 1'b1;
        bus.hsync_i    = 1'b0;
        bus.vsync_i    = 1'b0;
        bus.pri_wr     = 1'b0;
        bus.pri_line_i = 8'h00;
        bus.ivr_wr     = 1'b0;
        bus.ivr_i      = 8'h00;
        bus.dma_irq    = 3'b000;
        bus.int_enable = 1'b0;
        bus.cpu_ack    = 1'b0;
        cyc(3);
        chk("rst_int_n", 32'(bus.int_n), 32'h1);
        chk("rst_vector", 32'(bus.vector), 32'h00);
        chk("rst_pending", 32'(bus.pending), 32'h0);
        reset = 1'b0;
        cyc(2);

        // ivr bits 2:0 are discarded in the vector
        bus.ivr_wr = 1'b1;
        bus.ivr_i  = 8'h47;
        cyc(1);
        bus.ivr_wr     = 1'b0;
        bus.int_enable = 1'b1;

        // Frame interrupt: the first clock that samples VSYNC low is edge 0, and int_n falls at edge 1666
        vsync_drop();
        cyc(1666);
        chk("frame_int_n_early", 32'(bus.int_n), 32'h1);
        cyc(1);
        chk("frame_int_n", 32'(bus.int_n), 32'h0);
        chk("frame_pending", 32'(bus.pending), 32'h1);
        bus.cpu_ack = 1'b1;
        cyc(2);
        chk("frame_vector", 32'(bus.vector), 32'h40);
        chk("frame_ack_clr", 32'(bus.pending), 32'h0);
        chk("frame_ack_int_n_lat", 32'(bus.int_n), 32'h0);
        cyc(1);
        chk("frame_ack_int_n", 32'(bus.int_n), 32'h1);
        bus.cpu_ack = 1'b0;
        cyc(2);

        // VSYNC reload aborts the running count
        vsync_drop();
        cyc(500);
        vsync_drop();
        cyc(1665);
        chk("reload_no_early", 32'(bus.pending), 32'h0);
        cyc(1);
        chk("reload_fire", 32'(bus.pending), 32'h1);
        ack_pulse();
        chk("reload_ack", 32'(bus.pending), 32'h0);

        // A non-zero pri_line write cancels the countdown
        vsync_drop();
        cyc(100);
        pri_write(8'd5);
        cyc(2000);
        chk("pri_cancel", 32'(bus.pending), 32'h0);

        // Raster compare on line 5
        vsync_drop();
        cyc(3);
        for (int i = 0; i < 4; i++) hsync_pulse();
        chk("raster_line4", 32'(bus.pending), 32'h0);
        hsync_pulse();
        chk("raster_line5", 32'(bus.pending), 32'h1);
        ack_pulse();
        chk("raster_vector", 32'(bus.vector), 32'h40);
        chk("raster_ack", 32'(bus.pending), 32'h0);
        hsync_pulse();
        cyc(1800);
        chk("raster_only_once", 32'(bus.pending), 32'h0);

        // line_cnt saturates at 255: no wrap back through line 3
        pri_write(8'hFF);
        vsync_drop();
        cyc(3);
        for (int i = 0; i < 255; i++) hsync_pulse();
        chk("line_255_hit", 32'(bus.pending), 32'h1);
        ack_pulse();
        pri_write(8'd3);
        for (int i = 0; i < 5; i++) hsync_pulse();
        chk("line_saturate", 32'(bus.pending), 32'h0);

        // DMA priority
        dma_pulse(3'b101);
        chk("dma_latch", 32'(bus.pending), 32'hA);
        cyc(1);
        chk("dma_int_n", 32'(bus.int_n), 32'h0);
        ack_pulse();
        chk("dma_vec1", 32'(bus.vector), 32'h42);
        chk("dma_pend1", 32'(bus.pending), 32'h2);
        ack_pulse();
        chk("dma_vec2", 32'(bus.vector), 32'h46);
        chk("dma_pend2", 32'(bus.pending), 32'h0);
        dma_pulse(3'b010);
        cyc(2);
        dma_pulse(3'b010);
        chk("dma_repeat", 32'(bus.pending), 32'h4);
        ack_pulse();
        chk("dma1_vec", 32'(bus.vector), 32'h44);
        chk("dma1_clr", 32'(bus.pending), 32'h0);
        cyc(1);
        chk("dma_idle_int_n", 32'(bus.int_n), 32'h1);

        // A raster request outranks DMA0
        vsync_drop();
        cyc(3);
        for (int i = 0; i < 3; i++) hsync_pulse();
        dma_pulse(3'b001);
        chk("mix_pending", 32'(bus.pending), 32'h3);
        ack_pulse();
        chk("mix_vec", 32'(bus.vector), 32'h40);
        chk("mix_left", 32'(bus.pending), 32'h2);
        chk("mix_int_n", 32'(bus.int_n), 32'h0);
        ack_pulse();
        chk("mix_vec2", 32'(bus.vector), 32'h46);

        // An acknowledge with nothing pending returns the base vector
        ack_pulse();
        chk("empty_vec", 32'(bus.vector), 32'h40);
        chk("empty_pend", 32'(bus.pending), 32'h0);
        cyc(5);
        chk("vec_hold", 32'(bus.vector), 32'h40);

        // A set and a clear of one bit in the same cycle leave the bit set
        dma_pulse(3'b001);
        bus.cpu_ack = 1'b1;
        cyc(1);
        bus.dma_irq = 3'b001;
        cyc(1);
        bus.dma_irq = 3'b000;
        chk("setclr_vec", 32'(bus.vector), 32'h46);
        chk("setclr_pend", 32'(bus.pending), 32'h2);
        bus.cpu_ack = 1'b0;
        cyc(1);
        ack_pulse();
        chk("setclr_final", 32'(bus.pending), 32'h0);

        // int_enable gates int_n but not the pending latches
        bus.int_enable = 1'b0;
        dma_pulse(3'b010);
        cyc(3);
        chk("gate_int_n", 32'(bus.int_n), 32'h1);
        chk("gate_pending", 32'(bus.pending), 32'h4);
        bus.int_enable = 1'b1;
        cyc(1);
        chk("ungate_int_n", 32'(bus.int_n), 32'h0);
        ack_pulse();

        // Reset in the middle of a frame countdown
        pri_write(8'd0);
        cyc(2);
        vsync_drop();
        cyc(100);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("midrst_int_n", 32'(bus.int_n), 32'h1);
        chk("midrst_vector", 32'(bus.vector), 32'h00);
        chk("midrst_pending", 32'(bus.pending), 32'h0);
        cyc(1700);
        chk("midrst_no_frame", 32'(bus.pending), 32'h0);
        chk("midrst_int_n_late", 32'(bus.int_n), 32'h1);
        dma_pulse(3'b001);
        ack_pulse();
        chk("midrst_ivr_clr", 32'(bus.vector), 32'h06);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/plus_int_ctrl.md
PLUS_INT_CTRL -- requirements
Module: plus_int_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 32_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter FRAME_DELAY_US, default 52, frame-interrupt delay after VSYNC falling edge, in µs.
REQ-003 SHALL have parameter NUM_DMA, default 3, number of DMA interrupt sources, legal range 1..3.
REQ-004 SHALL have parameter LINE_W, default 8, width of the line counter and raster compare.
REQ-005 Ports, as name, direction, width, meaning:
- clk  in  1  system clock; one clock domain only.
- reset  in  1  synchronous, active-high reset.
- hsync_i  in  1  Gate-Array HSYNC level.
- vsync_i  in  1  Gate-Array VSYNC level.
- pri_wr  in  1  1-cycle strobe to load pri_line_i.
- pri_line_i  in  LINE_W  raster compare line; 0 selects frame mode.
- ivr_wr  in  1  1-cycle strobe to load ivr_i.
- ivr_i  in  8  vector base; bits 7:3 are used.
- dma_irq  in  NUM_DMA  per-channel 1-cycle request pulses.
- int_enable  in  1  MRER bit 4, global interrupt enable.
- cpu_ack  in  1  level, high during a Z80 INT-acknowledge cycle.
- int_n  out  1  active-low interrupt, registered.
- vector  out  8  IM2 vector for the current acknowledge.
- pending  out  NUM_DMA+1  bit 0 is raster/frame; bit k is DMA channel k-1.

Function
REQ-006 SHALL register hsync_i, vsync_i and cpu_ack once, and act only on their edges.
REQ-007 SHALL clear line_cnt on the VSYNC falling edge.
REQ-008 SHALL increment line_cnt on each HSYNC falling edge, saturating at all-ones with no wrap.
REQ-009 When HSYNC falling and VSYNC falling coincide, SHALL let the clear win.
REQ-010 Frame mode (pri_line = 0): the VSYNC falling edge SHALL load the timer with CLK_FREQ_HZ/1_000_000*FRAME_DELAY_US.
REQ-011 Frame mode: the timer SHALL decrement each clock; the transition 1->0 SHALL set pending[0]; the timer SHALL stop at 0.
REQ-012 A new VSYNC falling edge during countdown SHALL reload the timer and SHALL NOT set pending[0] for the aborted count.
REQ-013 Raster mode (pri_line != 0): the HSYNC falling edge that makes line_cnt == pri_line SHALL set pending[0] the following cycle.
REQ-014 Raster mode: the frame timer SHALL be held at 0.
REQ-015 pri_wr SHALL take effect for edges detected from the next cycle.
REQ-016 pri_wr during a frame countdown SHALL cancel the countdown if the new value is non-zero.
REQ-017 dma_irq[k] high SHALL set pending[k+1] the next cycle; a repeat pulse while set SHALL leave it set (no counting, no overflow).
REQ-018 Priority, highest first: pending[0], then DMA highest index down to DMA0.
REQ-019 int_n SHALL equal NOT(OR(pending) AND int_enable), registered, giving 1-cycle latency from a pending change.
REQ-020 With int_enable=0, sources SHALL still latch pending; raising int_enable SHALL assert int_n 1 cycle later.
REQ-021 On the cpu_ack rising edge, SHALL latch vector = {ivr[7:3], code[1:0], 0}.
REQ-022 code SHALL be: raster=00, DMA2=01, DMA1=10, DMA0=11.
REQ-023 On the cpu_ack rising edge, SHALL clear the winning pending bit the next cycle; only that bit SHALL clear.
REQ-024 A cpu_ack edge with nothing pending SHALL produce vector = {ivr[7:3],000} and clear nothing.
REQ-025 Set and clear of the same pending bit in one cycle: set SHALL win.
REQ-026 vector SHALL hold its value until the next cpu_ack rising edge.

Reset
REQ-027 reset SHALL force within one cycle: int_n=1, vector=0, pending=0, ivr=0, pri_line=0, line_cnt=0, timer=0, edge registers=0.
REQ-028 reset SHALL take priority over every other event, including mid-countdown and mid-acknowledge.

Verification
REQ-029 Frame mode, 32 MHz, int_enable=1, VSYNC falls -> int_n low exactly 1664+2 cycles after the edge; cpu_ack -> vector=ivr&F8, int_n high 2 cycles later.
REQ-030 pri_line=5, 6 HSYNC pulses after VSYNC falls -> pending[0] set after the 5th HSYNC falling edge only; no frame interrupt.
REQ-031 dma_irq=3'b101 in one cycle with ivr=0x40, then two acks -> first vector 0x42 (DMA2), second 0x46 (DMA0), pending ends 0.
REQ-032 Raster pending plus dma_irq[0] -> ack returns 0x40; the DMA0 bit remains and int_n stays low.
REQ-033 int_enable=0 with a DMA pulse -> int_n stays 1, pending[1]=1; int_enable=1 -> int_n=0 next cycle.
REQ-034 reset asserted 100 cycles into a countdown -> no interrupt for that frame; all outputs at reset values.
